alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the
//  execute stage. It serves MULT/MULTU/DIV/DIVU and MTHI/MTLO, and owns the HI/LO registers.
//  Multiply is iterative shift-add and divide is iterative restoring, one bit per cycle.
//  The pipeline stalls on MD_Busy.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; WIDTH >= 4
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      synchronous reset, active low
//  MD_Start  in   1      one-cycle request; sampled only in IDLE
//  MD_Op     in   3      000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
//  MD_DA     in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//  MD_DB     in   WIDTH  multiplier / divisor
//  MD_HI     out  WIDTH  HI register: product high half or remainder
//  MD_LO     out  WIDTH  LO register: product low half or quotient
//  MD_Busy   out  1      high while state != IDLE
//  MD_Done   out  1      one-cycle pulse in the cycle HI/LO first show a mul/div result
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, MD_HI=0, MD_LO=0, MD_Busy=0, MD_Done=0, iteration count=0.
//  Reset wins over every other input, including mid-operation: the operation is aborted, no partial result.
//  FSM: IDLE -> RUN -> FIXUP -> IDLE.
//   IDLE:  on edge E0 with MD_Start=1 and Op = mul/div:
//          - latch |DA| and |DB| (signed ops use magnitude); latch the result signs, div-by-zero flag and op kind
//          - clear the count; go to RUN.
//          On edge with MD_Start=1 and Op = MTHI/MTLO: write DA to HI/LO at that edge; stay IDLE; no Done.
//          Op 11x, or MD_Start=0: no effect.
//   RUN:   one iteration per edge; after exactly WIDTH edges (E1..E_WIDTH) go to FIXUP.
//          - MUL: 2*WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
//          - DIV: restoring shift-subtract; quotient bit = no-borrow.
//   FIXUP: at E_(WIDTH+1), apply sign correction and write HI/LO; MD_Done=1 for the following cycle; go to IDLE.
//  Latency: HI/LO are valid WIDTH+1 edges after the start edge. MD_Busy is high for WIDTH+1 cycles.
//   The earliest next start is accepted at E_(WIDTH+2).
//  MD_Start while busy (RUN/FIXUP): ignored, including MTHI/MTLO. The issuer must hold the request until !MD_Busy.
//  Signed MUL: {HI,LO} = two's-complement product; negate the 2*WIDTH magnitude if the signs differ.
//  Signed DIV: quotient truncates toward zero (negate if the signs differ); remainder takes the sign of the dividend.
//   MIN/-1 wraps: LO=MIN, HI=0.
//  Divide by zero (DB==0, signed or unsigned): full latency still elapses; HI=DA (as given), LO={WIDTH{1'b1}}.
//  HI/LO hold their value in all cycles except an MTHI/MTLO write edge or the FIXUP edge.
// STRUCTURE
//  Shared include alu_defs.vh: MD_Op encodings (MD_MULTU..MD_MTLO) and FSM state encodings.
//   Shared with the ALU's ALUOp encodings.
//  One sub-module, md_sign_fix (combinational, WIDTH param):
//   - abs of the inputs at start
//   - conditional negate of the quotient/remainder/product at FIXUP.
//  FSM, count, accumulators and HI/LO live in alu_muldiv.
// TESTING (WIDTH=32, latency 33 edges)
//  1. MULTU DA=FFFFFFFF DB=FFFFFFFF -> after 33 edges HI=FFFFFFFE LO=00000001; Done 1 cycle; Busy 33 cycles.
//  2. MULT DA=FFFFFFFD(-3) DB=7 -> HI=FFFFFFFF LO=FFFFFFEB; DIV DA=FFFFFFF9(-7) DB=2 -> LO=FFFFFFFD HI=FFFFFFFF.
//  3. DIVU DA=100 DB=7 -> LO=14 HI=2; DIVU DA=12345678 DB=0 -> HI=12345678 LO=FFFFFFFF.
//     DIV DA=80000000 DB=FFFFFFFF -> LO=80000000 HI=0.
//  4. MULTU 3*5 in progress, then MD_Start with MTHI DA=AAAA at iteration 10 -> ignored;
//     result HI=0 LO=15 arrives on schedule. Then MTLO DA=55 while idle -> LO=55 next cycle, no Done.
//  5. rst_n=0 at iteration 12 of DIVU -> next cycle Busy=0 Done=0 HI=LO=0.
//     A following MULTU 6*7 -> LO=42 after 33 edges.
//  6. Back-to-back: start held through Busy -> second op accepted at E34, its result at E67.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: MD_Op values, FSM states and op decode helpers.
package alu_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULTU = 3'b000,
      MD_MULT  = 3'b001,
      MD_DIVU  = 3'b010,
      MD_DIV   = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2
   } md_state_e;

   function automatic logic op_is_muldiv(input logic [2:0] op);
      return !op[2];
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return op[1];
   endfunction

   // Only meaningful for mul/div encodings.
   function automatic logic op_is_signed(input logic [2:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/alu_muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes at start, conditional negation of the result at fixup.
module alu_muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   da,
   input  logic [WIDTH-1:0]   db,
   input  logic               is_signed,
   output logic [WIDTH-1:0]   abs_a,
   output logic [WIDTH-1:0]   abs_b,
   output logic               neg_a,
   output logic               neg_b,
   input  logic [2*WIDTH-1:0] res,
   input  logic               is_div,
   input  logic               neg_lo,
   input  logic               neg_hi,
   output logic [2*WIDTH-1:0] fixed
);

   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   always_comb begin
      neg_a  = is_signed & da[WIDTH-1];
      neg_b  = is_signed & db[WIDTH-1];
      abs_a  = neg_a ? -da : da;
      abs_b  = neg_b ? -db : db;
      res_hi = res[2*WIDTH-1:WIDTH];
      res_lo = res[WIDTH-1:0];
      // Divide fixes quotient and remainder independently; multiply negates the full product.
      if (is_div) begin
         fixed = {(neg_hi ? -res_hi : res_hi), (neg_lo ? -res_lo : res_lo)};
      end else begin
         fixed = neg_lo ? -res : res;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MD_Start,
   input  logic [2:0]       MD_Op,
   input  logic [WIDTH-1:0] MD_DA,
   input  logic [WIDTH-1:0] MD_DB,
   output logic [WIDTH-1:0] MD_HI,
   output logic [WIDTH-1:0] MD_LO,
   output logic             MD_Busy,
   output logic             MD_Done
);

   localparam int CW = $clog2(WIDTH + 1);

   md_state_e          state_reg;
   logic [CW-1:0]      count_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   opnd_reg;
   logic [WIDTH-1:0]   da_raw_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               is_div_reg;
   logic               neg_lo_reg;
   logic               neg_hi_reg;
   logic               div_zero_reg;
   logic               done_reg;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               neg_a;
   logic               neg_b;
   logic [2*WIDTH-1:0] fixed;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;

   alu_muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .da        (MD_DA),
      .db        (MD_DB),
      .is_signed (op_is_signed(MD_Op)),
      .abs_a     (abs_a),
      .abs_b     (abs_b),
      .neg_a     (neg_a),
      .neg_b     (neg_b),
      .res       (acc_reg),
      .is_div    (is_div_reg),
      .neg_lo    (neg_lo_reg),
      .neg_hi    (neg_hi_reg),
      .fixed     (fixed)
   );

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   always_comb begin
      mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      rem_sh  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
      diff    = rem_sh - {1'b0, opnd_reg};
      if (is_div_reg) begin
         acc_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_reg[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         da_raw_reg   <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         is_div_reg   <= 1'b0;
         neg_lo_reg   <= 1'b0;
         neg_hi_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (MD_Start) begin
                  if (op_is_muldiv(MD_Op)) begin
                     is_div_reg   <= op_is_div(MD_Op);
                     div_zero_reg <= (MD_DB == '0);
                     da_raw_reg   <= MD_DA;
                     neg_lo_reg   <= neg_a ^ neg_b;
                     neg_hi_reg   <= neg_a;
                     opnd_reg     <= op_is_div(MD_Op) ? abs_b : abs_a;
                     acc_reg      <= {{WIDTH{1'b0}}, (op_is_div(MD_Op) ? abs_a : abs_b)};
                     count_reg    <= '0;
                     state_reg    <= ST_RUN;
                  end else if (MD_Op == MD_MTHI) begin
                     hi_reg <= MD_DA;
                  end else if (MD_Op == MD_MTLO) begin
                     lo_reg <= MD_DA;
                  end
               end
            end
            ST_RUN: begin
               acc_reg   <= acc_next;
               count_reg <= count_reg + CW'(1);
               if (count_reg == CW'(WIDTH - 1)) begin
                  state_reg <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               if (is_div_reg && div_zero_reg) begin
                  hi_reg <= da_raw_reg;
                  lo_reg <= '1;
               end else begin
                  hi_reg <= fixed[2*WIDTH-1:WIDTH];
                  lo_reg <= fixed[WIDTH-1:0];
               end
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign MD_HI   = hi_reg;
   assign MD_LO   = lo_reg;
   assign MD_Busy = (state_reg != ST_IDLE);
   assign MD_Done = done_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32: results, latency, busy/done timing, ignored starts, reset abort.
module tb_alu_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         MD_Start;
   logic [2:0]   MD_Op;
   logic [W-1:0] MD_DA;
   logic [W-1:0] MD_DB;
   logic [W-1:0] MD_HI;
   logic [W-1:0] MD_LO;
   logic         MD_Busy;
   logic         MD_Done;

   int pass_count  = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .MD_Start (MD_Start),
      .MD_Op    (MD_Op),
      .MD_DA    (MD_DA),
      .MD_DB    (MD_DB),
      .MD_HI    (MD_HI),
      .MD_LO    (MD_LO),
      .MD_Busy  (MD_Busy),
      .MD_Done  (MD_Done)
   );

   // Issues one request and watches 40 edges; sample k is taken 1ns after edge E_k.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy_n, output int done_n, output int done_at);
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      @(negedge clk);
      MD_Start = 1'b1; MD_Op = op; MD_DA = a; MD_DB = b;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (MD_Busy) busy_n++;
         if (MD_Done) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         @(posedge clk); #1;
      end
      $display("op=%0d da=%h db=%h -> hi=%h lo=%h busy=%0d done_at=%0d",
               op, a, b, MD_HI, MD_LO, busy_n, done_at);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; MD_Start = 1'b0; MD_Op = 3'b000; MD_DA = '0; MD_DB = '0;
      repeat (3) @(posedge clk);
      #1;
      check_count++; if (MD_HI !== 32'h0) $display("FAIL reset_hi: got %h want 00000000", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'h0) $display("FAIL reset_lo: got %h want 00000000", MD_LO); else pass_count++;
      check_count++; if (MD_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", MD_Busy); else pass_count++;
      check_count++; if (MD_Done !== 1'b0) $display("FAIL reset_done: got %b want 0", MD_Done); else pass_count++;
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_multu();
      int bn, dn, at;
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, dn, at);
      check_count++; if (MD_HI !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want FFFFFFFE", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", MD_LO); else pass_count++;
      check_count++; if (bn !== 33) $display("FAIL multu_busy_cycles: got %0d want 33", bn); else pass_count++;
      check_count++; if (dn !== 1) $display("FAIL multu_done_pulses: got %0d want 1", dn); else pass_count++;
      check_count++; if (at !== 33) $display("FAIL multu_latency: got %0d want 33", at); else pass_count++;
   endtask

   task automatic test_signed();
      int bn, dn, at;
      run_op(3'b001, 32'hFFFF_FFFD, 32'h0000_0007, bn, dn, at);
      check_count++; if (MD_HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want FFFFFFFF", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h want FFFFFFEB", MD_LO); else pass_count++;
      run_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, bn, dn, at);
      check_count++; if (MD_LO !== 32'hFFFF_FFFD) $display("FAIL div_quot: got %h want FFFFFFFD", MD_LO); else pass_count++;
      check_count++; if (MD_HI !== 32'hFFFF_FFFF) $display("FAIL div_rem: got %h want FFFFFFFF", MD_HI); else pass_count++;
      check_count++; if (at !== 33) $display("FAIL div_latency: got %0d want 33", at); else pass_count++;
   endtask

   task automatic test_div();
      int bn, dn, at;
      run_op(3'b010, 32'd100, 32'd7, bn, dn, at);
      check_count++; if (MD_LO !== 32'd14) $display("FAIL divu_quot: got %h want 0000000e", MD_LO); else pass_count++;
      check_count++; if (MD_HI !== 32'd2) $display("FAIL divu_rem: got %h want 00000002", MD_HI); else pass_count++;
      run_op(3'b010, 32'h1234_5678, 32'h0, bn, dn, at);
      check_count++; if (MD_HI !== 32'h1234_5678) $display("FAIL divu_zero_hi: got %h want 12345678", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'hFFFF_FFFF) $display("FAIL divu_zero_lo: got %h want FFFFFFFF", MD_LO); else pass_count++;
      check_count++; if (at !== 33) $display("FAIL divu_zero_latency: got %0d want 33", at); else pass_count++;
      run_op(3'b011, 32'hFFFF_FFF9, 32'h0, bn, dn, at);
      check_count++; if (MD_HI !== 32'hFFFF_FFF9) $display("FAIL div_zero_hi: got %h want FFFFFFF9", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'hFFFF_FFFF) $display("FAIL div_zero_lo: got %h want FFFFFFFF", MD_LO); else pass_count++;
      run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, at);
      check_count++; if (MD_LO !== 32'h8000_0000) $display("FAIL div_min_quot: got %h want 80000000", MD_LO); else pass_count++;
      check_count++; if (MD_HI !== 32'h0) $display("FAIL div_min_rem: got %h want 00000000", MD_HI); else pass_count++;
   endtask

   task automatic test_busy_ignore();
      int at;
      at = -1;
      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b000; MD_DA = 32'd3; MD_DB = 32'd5;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) begin
            MD_Start = 1'b1; MD_Op = 3'b100; MD_DA = 32'h0000_AAAA;
         end
         if (k == 11) MD_Start = 1'b0;
         if (k == 12) begin
            check_count++; if (MD_HI !== 32'h0) $display("FAIL mthi_busy_hi: got %h want 00000000", MD_HI); else pass_count++;
         end
         if (MD_Done && at < 0) at = k;
         @(posedge clk); #1;
      end
      $display("op=0 da=3 db=5 with mthi while busy -> hi=%h lo=%h done_at=%0d", MD_HI, MD_LO, at);
      check_count++; if (at !== 33) $display("FAIL ignore_latency: got %0d want 33", at); else pass_count++;
      check_count++; if (MD_HI !== 32'h0) $display("FAIL ignore_hi: got %h want 00000000", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'd15) $display("FAIL ignore_lo: got %h want 0000000f", MD_LO); else pass_count++;

      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b101; MD_DA = 32'h55;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      $display("mtlo da=00000055 -> lo=%h", MD_LO);
      check_count++; if (MD_LO !== 32'h55) $display("FAIL mtlo_lo: got %h want 00000055", MD_LO); else pass_count++;
      check_count++; if (MD_Done !== 1'b0) $display("FAIL mtlo_done: got %b want 0", MD_Done); else pass_count++;
      check_count++; if (MD_Busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", MD_Busy); else pass_count++;

      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b110; MD_DA = 32'hFFFF;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      $display("noop da=0000ffff -> hi=%h lo=%h", MD_HI, MD_LO);
      check_count++; if (MD_LO !== 32'h55) $display("FAIL noop_lo: got %h want 00000055", MD_LO); else pass_count++;
      check_count++; if (MD_Busy !== 1'b0) $display("FAIL noop_busy: got %b want 0", MD_Busy); else pass_count++;

      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b100; MD_DA = 32'h1234;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      $display("mthi da=00001234 -> hi=%h", MD_HI);
      check_count++; if (MD_HI !== 32'h1234) $display("FAIL mthi_hi: got %h want 00001234", MD_HI); else pass_count++;
   endtask

   task automatic test_reset_abort();
      int bn, dn, at;
      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b010; MD_DA = 32'd1000; MD_DB = 32'd3;
      @(posedge clk); #1;
      MD_Start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check_count++; if (MD_Busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", MD_Busy); else pass_count++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      $display("reset during divu -> hi=%h lo=%h busy=%b", MD_HI, MD_LO, MD_Busy);
      check_count++; if (MD_Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", MD_Busy); else pass_count++;
      check_count++; if (MD_Done !== 1'b0) $display("FAIL abort_done: got %b want 0", MD_Done); else pass_count++;
      check_count++; if (MD_HI !== 32'h0) $display("FAIL abort_hi: got %h want 00000000", MD_HI); else pass_count++;
      check_count++; if (MD_LO !== 32'h0) $display("FAIL abort_lo: got %h want 00000000", MD_LO); else pass_count++;
      rst_n = 1'b1;
      run_op(3'b000, 32'd6, 32'd7, bn, dn, at);
      check_count++; if (MD_LO !== 32'd42) $display("FAIL post_abort_lo: got %h want 0000002a", MD_LO); else pass_count++;
      check_count++; if (at !== 33) $display("FAIL post_abort_latency: got %0d want 33", at); else pass_count++;
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd;
      logic [W-1:0] lo_first;
      d1 = -1; d2 = -1; nd = 0; lo_first = '0;
      @(negedge clk);
      MD_Start = 1'b1; MD_Op = 3'b000; MD_DA = 32'd3; MD_DB = 32'd5;
      @(posedge clk); #1;
      MD_DA = 32'd6; MD_DB = 32'd7;
      for (int k = 0; k < 76; k++) begin
         if (MD_Done) begin
            nd++;
            if (d1 < 0) begin
               d1 = k;
               lo_first = MD_LO;
            end else if (d2 < 0) begin
               d2 = k;
            end
         end
         if (k == 34) begin
            check_count++; if (MD_Busy !== 1'b1) $display("FAIL b2b_second_accept: got busy %b want 1", MD_Busy); else pass_count++;
            MD_Start = 1'b0;
         end
         @(posedge clk); #1;
      end
      $display("back-to-back 3*5 then 6*7 -> first lo=%h at %0d, final lo=%h at %0d", lo_first, d1, MD_LO, d2);
      check_count++; if (d1 !== 33) $display("FAIL b2b_first_done: got %0d want 33", d1); else pass_count++;
      check_count++; if (lo_first !== 32'd15) $display("FAIL b2b_first_lo: got %h want 0000000f", lo_first); else pass_count++;
      check_count++; if (d2 !== 67) $display("FAIL b2b_second_done: got %0d want 67", d2); else pass_count++;
      check_count++; if (MD_LO !== 32'd42) $display("FAIL b2b_second_lo: got %h want 0000002a", MD_LO); else pass_count++;
      check_count++; if (nd !== 2) $display("FAIL b2b_done_pulses: got %0d want 2", nd); else pass_count++;
   endtask

   initial begin
      test_reset();
      test_multu();
      test_signed();
      test_div();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
